// File: rtl/multicycle_ctrl_if.sv
// Purpose : handshake/strobe bundle between multicycle_ctrl and its datapath/memories.
// Latency : n/a (wires only).
// Backpressure: carried by in_imem_ready / in_dmem_ready.
// Ports   : master = the controller (drives out_*), slave = datapath/memory side (drives in_*).
//           The perf counters exist only when MULTICYCLE_CTRL_PERF_CNT_EN is defined.
interface multicycle_ctrl_if;
   logic        in_run;
   logic [31:0] in_inst;
   logic        in_imem_ready;
   logic        in_dmem_ready;
   logic        out_imem_req;
   logic        out_ir_we;
   logic        out_dmem_req;
   logic        out_dmem_we;
   logic        out_pc_we;
   logic        out_int_rf_we;
   logic        out_fp_rf_we;
   logic [2:0]  out_state;
   logic        out_trap;
   logic [1:0]  out_trap_cause;
`ifdef MULTICYCLE_CTRL_PERF_CNT_EN
   logic [63:0] out_cycle_cnt;
   logic [63:0] out_instret_cnt;
`endif

   modport master (
      input  in_run, in_inst, in_imem_ready, in_dmem_ready,
      output out_imem_req, out_ir_we, out_dmem_req, out_dmem_we, out_pc_we,
             out_int_rf_we, out_fp_rf_we, out_state, out_trap, out_trap_cause
`ifdef MULTICYCLE_CTRL_PERF_CNT_EN
      , output out_cycle_cnt, out_instret_cnt
`endif
   );

   modport slave (
      output in_run, in_inst, in_imem_ready, in_dmem_ready,
      input  out_imem_req, out_ir_we, out_dmem_req, out_dmem_we, out_pc_we,
             out_int_rf_we, out_fp_rf_we, out_state, out_trap, out_trap_cause
`ifdef MULTICYCLE_CTRL_PERF_CNT_EN
      , input out_cycle_cnt, out_instret_cnt
`endif
   );
endinterface

// File: rtl/multicycle_ctrl.sv
// Purpose : FETCH/DECODE/EXEC/MEM/WB sequencer gating IR, PC, RF and memory strobes for an RV64 datapath.
// Latency : strobes are same-cycle decodes of registered state/counters and inputs; one state step per clock.
// Backpressure: stalls in FETCH until in_imem_ready, in MEM until in_dmem_ready (traps after MEM_TIMEOUT cycles).
// Ports   : Clk, Rst (synchronous, active-low); bus = multicycle_ctrl_if.master.
// Option  : define MULTICYCLE_CTRL_PERF_CNT_EN to add out_cycle_cnt / out_instret_cnt.
module multicycle_ctrl #(
   parameter int FPU_LATENCY = 4,
   parameter int MEM_TIMEOUT = 255
) (
   input  logic               Clk,
   input  logic               Rst,
   multicycle_ctrl_if.master  bus
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_TRAP   = 3'd7
   } state_t;

   localparam int FW = (FPU_LATENCY > 1) ? $clog2(FPU_LATENCY) : 1;
   localparam int TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [FW-1:0] FPU_LAST = FW'(FPU_LATENCY - 1);
   localparam logic [TW-1:0] TO_LAST  = TW'(MEM_TIMEOUT - 1);

   state_t        state;
   logic [FW-1:0] fpu_cnt;
   logic [TW-1:0] to_cnt;
   logic          trap;
   logic [1:0]    trap_cause;

   // Instruction classification (IR is stable for the whole instruction)
   logic [6:0] opc;
   logic       is_load, is_store, is_load_fp, is_store_fp, is_op_fp, is_branch;
   logic       is_legal, is_mem_op, is_any_store, fp_to_int, fp_dest, rd_zero;

   assign opc = bus.in_inst[6:0];

   always_comb begin
      is_load     = (opc == 7'b0000011);
      is_store    = (opc == 7'b0100011);
      is_load_fp  = (opc == 7'b0000111);
      is_store_fp = (opc == 7'b0100111);
      is_op_fp    = (opc == 7'b1010011);
      is_branch   = (opc == 7'b1100011);
      is_legal    = 1'b0;
      case (opc)
         7'b0000011, 7'b0100011, 7'b0000111, 7'b0100111, 7'b1010011,
         7'b0110011, 7'b0010011, 7'b0111011, 7'b0011011, 7'b0110111,
         7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011: is_legal = 1'b1;
         default:                                          is_legal = 1'b0;
      endcase
   end

   assign is_mem_op    = is_load | is_store | is_load_fp | is_store_fp;
   assign is_any_store = is_store | is_store_fp;
   // FP compare (10100), convert-to-int (11000) and move/class (11100) land in the integer RF
   assign fp_to_int    = (bus.in_inst[31:27] == 5'b10100) ||
                         (bus.in_inst[31:27] == 5'b11000) ||
                         (bus.in_inst[31:27] == 5'b11100);
   assign fp_dest      = is_load_fp | (is_op_fp & ~fp_to_int);
   assign rd_zero      = (bus.in_inst[11:7] == 5'd0);

   logic exec_last, mem_expire;
   assign exec_last  = ~is_op_fp | (fpu_cnt == FPU_LAST);
   // ready in the limit cycle takes priority over the timeout
   assign mem_expire = ~bus.in_dmem_ready & (to_cnt == TO_LAST);

   // Strobes
   logic pc_we;
   assign pc_we = ((state == S_EXEC) & exec_last & is_branch) |
                  ((state == S_MEM) & bus.in_dmem_ready & is_any_store) |
                  (state == S_WB);

   assign bus.out_imem_req   = (state == S_FETCH) & bus.in_run;
   assign bus.out_ir_we      = (state == S_FETCH) & bus.in_run & bus.in_imem_ready;
   assign bus.out_dmem_req   = (state == S_MEM);
   assign bus.out_dmem_we    = (state == S_MEM) & is_any_store;
   assign bus.out_pc_we      = pc_we;
   assign bus.out_fp_rf_we   = (state == S_WB) & fp_dest;
   assign bus.out_int_rf_we  = (state == S_WB) & ~fp_dest & ~rd_zero;
   assign bus.out_state      = state;
   assign bus.out_trap       = trap;
   assign bus.out_trap_cause = trap_cause;

   always_ff @(posedge Clk) begin
      if (!Rst) begin
         state      <= S_FETCH;
         fpu_cnt    <= '0;
         to_cnt     <= '0;
         trap       <= 1'b0;
         trap_cause <= 2'd0;
      end else begin
         case (state)
            S_FETCH: begin
               if (bus.in_run && bus.in_imem_ready) state <= S_DECODE;
            end
            S_DECODE: begin
               if (is_legal) begin
                  state <= S_EXEC;
               end else begin
                  state      <= S_TRAP;
                  trap       <= 1'b1;
                  trap_cause <= 2'd1;
               end
            end
            S_EXEC: begin
               if (exec_last) begin
                  fpu_cnt <= '0;
                  state   <= is_mem_op ? S_MEM : (is_branch ? S_FETCH : S_WB);
               end else begin
                  fpu_cnt <= fpu_cnt + 1'b1;
               end
            end
            S_MEM: begin
               if (bus.in_dmem_ready) begin
                  to_cnt <= '0;
                  state  <= is_any_store ? S_FETCH : S_WB;
               end else if (mem_expire) begin
                  to_cnt     <= '0;
                  state      <= S_TRAP;
                  trap       <= 1'b1;
                  trap_cause <= 2'd2;
               end else begin
                  to_cnt <= to_cnt + 1'b1;
               end
            end
            S_WB:    state <= S_FETCH;
            S_TRAP:  state <= S_TRAP;
            default: state <= S_FETCH;   // codes 5/6 recover to FETCH
         endcase
      end
   end

`ifdef MULTICYCLE_CTRL_PERF_CNT_EN
   logic [63:0] cycle_cnt, instret_cnt;
   always_ff @(posedge Clk) begin
      if (!Rst) begin
         cycle_cnt   <= '0;
         instret_cnt <= '0;
      end else begin
         if (state != S_TRAP) cycle_cnt   <= cycle_cnt + 64'd1;
         if (pc_we)           instret_cnt <= instret_cnt + 64'd1;
      end
   end
   assign bus.out_cycle_cnt   = cycle_cnt;
   assign bus.out_instret_cnt = instret_cnt;
`endif

   // funct5 low bits outside [31:27], rs fields and funct3 are not needed for sequencing
   logic unused_inst_bits;
   assign unused_inst_bits = ^bus.in_inst[26:12];

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;

   logic Clk = 1'b0;
   logic Rst = 1'b0;
   always #5 Clk = ~Clk;

   multicycle_ctrl_if bus();

   multicycle_ctrl #(.FPU_LATENCY(4), .MEM_TIMEOUT(255)) dut (
      .Clk (Clk),
      .Rst (Rst),
      .bus (bus)
   );

   // Expected output snapshot for one cycle
   typedef struct packed {
      logic [2:0] state;
      logic       imem_req, ir_we, dmem_req, dmem_we, pc_we, int_we, fp_we;
      logic       trap;
      logic [1:0] cause;
   } exp_t;

   typedef struct packed {
      logic        rst_n;
      logic        run;
      logic [31:0] inst;
      logic        imr;
      logic        dmr;
      exp_t        e;
   } vec_t;

   localparam logic [2:0] F = 3'd0, D = 3'd1, E = 3'd2, M = 3'd3, W = 3'd4, T = 3'd7;
   // strobe order: imem_req ir_we dmem_req dmem_we pc_we int_we fp_we
   localparam logic [6:0] NONE   = 7'b0000000;
   localparam logic [6:0] REQ    = 7'b1000000;
   localparam logic [6:0] FET    = 7'b1100000;
   localparam logic [6:0] MEMR   = 7'b0010000;
   localparam logic [6:0] MEMW   = 7'b0011000;
   localparam logic [6:0] MEMWPC = 7'b0011100;
   localparam logic [6:0] PC     = 7'b0000100;
   localparam logic [6:0] PCINT  = 7'b0000110;
   localparam logic [6:0] PCFP   = 7'b0000101;

   localparam logic [31:0] ADDI5  = 32'h00500293;
   localparam logic [31:0] ADDI0  = 32'h00000013;
   localparam logic [31:0] LW     = 32'h0002A303;
   localparam logic [31:0] SW     = 32'h0062A023;
   localparam logic [31:0] FLW    = 32'h0002A087;
   localparam logic [31:0] FADD   = 32'h003100D3;
   localparam logic [31:0] FEQ    = 32'hA03120D3;
   localparam logic [31:0] FMVX0  = 32'hE0000053;
   localparam logic [31:0] BEQ    = 32'h00000063;
   localparam logic [31:0] ILL    = 32'h00000000;

   vec_t tbl[$];
   exp_t sb[$];
   int   n_pass  = 0;
   int   n_total = 0;

   function automatic exp_t ex(input logic [2:0] st, input logic [6:0] stb,
                               input logic tr, input logic [1:0] c);
      exp_t r;
      r.state = st;
      {r.imem_req, r.ir_we, r.dmem_req, r.dmem_we, r.pc_we, r.int_we, r.fp_we} = stb;
      r.trap  = tr;
      r.cause = c;
      return r;
   endfunction

   function automatic void add(input logic rn, input logic run, input logic [31:0] inst,
                               input logic imr, input logic dmr, input exp_t e);
      vec_t v;
      v.rst_n = rn; v.run = run; v.inst = inst; v.imr = imr; v.dmr = dmr; v.e = e;
      tbl.push_back(v);
   endfunction

   // FETCH + DECODE prefix of a normal instruction
   function automatic void add_fd(input logic [31:0] inst);
      add(1, 1, inst, 1, 0, ex(F, FET, 0, 0));
      add(1, 1, inst, 1, 1, ex(D, NONE, 0, 0));
   endfunction

   task automatic drive(input logic rn, input logic run, input logic [31:0] inst,
                        input logic imr, input logic dmr, input exp_t e);
      @(posedge Clk);
      #1;
      Rst               = rn;
      bus.in_run        = run;
      bus.in_inst       = inst;
      bus.in_imem_ready = imr;
      bus.in_dmem_ready = dmr;
      sb.push_back(e);
   endtask

   task automatic drive_fde(input logic [31:0] inst);
      drive(1, 1, inst, 1, 0, ex(F, FET, 0, 0));
      drive(1, 1, inst, 0, 0, ex(D, NONE, 0, 0));
      drive(1, 1, inst, 0, 0, ex(E, NONE, 0, 0));
   endtask

   // Scoreboard: compare the oldest expectation against the DUT mid-cycle
   always @(negedge Clk) begin
      if (sb.size() > 0) begin
         exp_t want, got;
         want = sb.pop_front();
         got  = {bus.out_state, bus.out_imem_req, bus.out_ir_we, bus.out_dmem_req,
                 bus.out_dmem_we, bus.out_pc_we, bus.out_int_rf_we, bus.out_fp_rf_we,
                 bus.out_trap, bus.out_trap_cause};
         n_total++;
         if (got === want) n_pass++;
         else $display("FAIL cycle%0d: got st=%0d stb=%b trap=%b cause=%0d, want st=%0d stb=%b trap=%b cause=%0d",
                       n_total, got.state,
                       {got.imem_req, got.ir_we, got.dmem_req, got.dmem_we, got.pc_we, got.int_we, got.fp_we},
                       got.trap, got.cause, want.state,
                       {want.imem_req, want.ir_we, want.dmem_req, want.dmem_we, want.pc_we, want.int_we, want.fp_we},
                       want.trap, want.cause);
      end
   end

   initial begin
      bus.in_run = 0; bus.in_inst = 0; bus.in_imem_ready = 0; bus.in_dmem_ready = 0;

      // ---------------- table ----------------
      add(1, 0, ADDI5, 1, 1, ex(F, NONE, 0, 0));            // reset state, idle
      add_fd(ADDI5);                                        // ADDI x5
      add(1, 1, ADDI5, 1, 1, ex(E, NONE, 0, 0));
      add(1, 1, ADDI5, 1, 1, ex(W, PCINT, 0, 0));
      add_fd(LW);                                           // LW, ready on 3rd MEM cycle
      add(1, 1, LW, 1, 0, ex(E, NONE, 0, 0));
      add(1, 1, LW, 1, 0, ex(M, MEMR, 0, 0));
      add(1, 1, LW, 1, 0, ex(M, MEMR, 0, 0));
      add(1, 1, LW, 1, 1, ex(M, MEMR, 0, 0));
      add(1, 1, LW, 1, 0, ex(W, PCINT, 0, 0));
      add_fd(SW);                                           // SW, ready on 3rd MEM cycle
      add(1, 1, SW, 1, 0, ex(E, NONE, 0, 0));
      add(1, 1, SW, 1, 0, ex(M, MEMW, 0, 0));
      add(1, 1, SW, 1, 0, ex(M, MEMW, 0, 0));
      add(1, 1, SW, 1, 1, ex(M, MEMWPC, 0, 0));
      add_fd(FADD);                                         // FADD.S f1: 4 EXEC cycles
      for (int i = 0; i < 4; i++) add(1, 1, FADD, 1, 1, ex(E, NONE, 0, 0));
      add(1, 1, FADD, 1, 1, ex(W, PCFP, 0, 0));
      add_fd(FEQ);                                          // FEQ.S x1 -> int RF
      for (int i = 0; i < 4; i++) add(1, 1, FEQ, 1, 1, ex(E, NONE, 0, 0));
      add(1, 1, FEQ, 1, 1, ex(W, PCINT, 0, 0));
      add_fd(FMVX0);                                        // FMV.X.W x0: int write suppressed
      for (int i = 0; i < 4; i++) add(1, 1, FMVX0, 1, 1, ex(E, NONE, 0, 0));
      add(1, 1, FMVX0, 1, 1, ex(W, PC, 0, 0));
      add_fd(BEQ);                                          // branch: PC write in EXEC
      add(1, 1, BEQ, 1, 1, ex(E, PC, 0, 0));
      add_fd(ADDI0);                                        // ADDI x0: no RF write
      add(1, 1, ADDI0, 1, 1, ex(E, NONE, 0, 0));
      add(1, 1, ADDI0, 1, 1, ex(W, PC, 0, 0));
      add_fd(FLW);                                          // FLW f1, immediate ready
      add(1, 1, FLW, 1, 0, ex(E, NONE, 0, 0));
      add(1, 1, FLW, 1, 1, ex(M, MEMR, 0, 0));
      add(1, 1, FLW, 1, 0, ex(W, PCFP, 0, 0));
      add(1, 1, ADDI5, 1, 0, ex(F, FET, 0, 0));             // run drops after fetch
      add(1, 0, ADDI5, 1, 0, ex(D, NONE, 0, 0));
      add(1, 0, ADDI5, 1, 0, ex(E, NONE, 0, 0));
      add(1, 0, ADDI5, 1, 0, ex(W, PCINT, 0, 0));
      add(1, 0, ADDI5, 1, 0, ex(F, NONE, 0, 0));
      add(1, 0, ADDI5, 1, 0, ex(F, NONE, 0, 0));
      add(1, 1, ADDI5, 0, 0, ex(F, REQ, 0, 0));             // request without ready: hold
      add(1, 1, ADDI5, 0, 0, ex(F, REQ, 0, 0));

      repeat (2) @(posedge Clk);
      for (int i = 0; i < tbl.size(); i++)
         drive(tbl[i].rst_n, tbl[i].run, tbl[i].inst, tbl[i].imr, tbl[i].dmr, tbl[i].e);

      // ---------------- illegal opcode trap, then reset ----------------
      drive(1, 1, ILL, 1, 0, ex(F, FET, 0, 0));
      drive(1, 1, ILL, 1, 1, ex(D, NONE, 0, 0));
      for (int i = 0; i < 22; i++) drive(1, 1, ILL, 1, 1, ex(T, NONE, 1, 1));
      drive(0, 1, ILL, 1, 1, ex(T, NONE, 1, 1));
      drive(1, 0, ILL, 0, 0, ex(F, NONE, 0, 0));

      // ---------------- dmem timeout: 255 MEM cycles then TRAP ----------------
      drive_fde(SW);
      for (int i = 0; i < 255; i++) drive(1, 1, SW, 1, 0, ex(M, MEMW, 0, 0));
      drive(1, 1, SW, 1, 1, ex(T, NONE, 1, 2));
      drive(0, 1, SW, 1, 1, ex(T, NONE, 1, 2));
      drive(1, 0, SW, 0, 0, ex(F, NONE, 0, 0));

      // ---------------- ready on the 255th MEM cycle wins ----------------
      drive_fde(SW);
      for (int i = 0; i < 254; i++) drive(1, 1, SW, 1, 0, ex(M, MEMW, 0, 0));
      drive(1, 1, SW, 1, 1, ex(M, MEMWPC, 0, 0));
      drive(1, 0, SW, 0, 0, ex(F, NONE, 0, 0));

      // ---------------- reset pulsed mid-MEM ----------------
      drive_fde(LW);
      drive(1, 1, LW, 0, 0, ex(M, MEMR, 0, 0));
      drive(0, 1, LW, 0, 0, ex(M, MEMR, 0, 0));
      drive(1, 0, LW, 1, 1, ex(F, NONE, 0, 0));

      // ---------------- reset pulsed mid-EXEC of an FP op ----------------
      drive(1, 1, FADD, 1, 0, ex(F, FET, 0, 0));
      drive(1, 1, FADD, 0, 0, ex(D, NONE, 0, 0));
      drive(1, 1, FADD, 0, 0, ex(E, NONE, 0, 0));
      drive(0, 0, FADD, 0, 0, ex(E, NONE, 0, 0));
      drive(1, 0, FADD, 0, 0, ex(F, NONE, 0, 0));

      @(posedge Clk);
      #1;
      if (sb.size() != 0) begin
         n_total++;
         $display("FAIL drain: %0d expectations left, want 0", sb.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
